// File: rtl/mac_seq_if.sv
// rtl/mac_seq_if.sv - handshake bundle for the mac_seq dot-product engine
// master drives pairs and out_ready; slave is the mac_seq datapath.
interface mac_seq_if #(
  parameter int DATSIZE = 22,
  parameter int PARSIZE = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [DATSIZE-1:0] in_data;
  logic signed [PARSIZE-1:0] in_weight;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DATSIZE-1:0] out_data;
  logic                      out_ovf;

  modport master (
    output in_valid, in_data, in_weight, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_weight, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - sequential fixed-point multiply-accumulate over TAPS pairs
// Optional macro MAC_SEQ_RELU_EN clamps negative saturated results to zero.
module mac_seq #(
  parameter int DATSIZE = 22,
  parameter int PARSIZE = 16,
  parameter int FPSHIFT = 14,
  parameter int TAPS    = 9,
  parameter int GUARD   = 4
) (
  input  logic      clk,
  input  logic      rst,
  mac_seq_if.slave  bus
);

  localparam int AW = DATSIZE + PARSIZE + GUARD;
  localparam int PW = DATSIZE + PARSIZE;
  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATSIZE+1){1'b0}}, {(DATSIZE-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATSIZE+1){1'b1}}, {(DATSIZE-1){1'b0}}};
  localparam logic signed [DATSIZE-1:0] RES_MAX = {1'b0, {(DATSIZE-1){1'b1}}};
  localparam logic signed [DATSIZE-1:0] RES_MIN = {1'b1, {(DATSIZE-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(TAPS - 1);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  state_t                    state;
  state_t                    state_nx;
  logic                      in_ready_c;
  logic                      out_valid_c;
  logic                      beat;
  logic                      last_beat;
  logic [CW-1:0]             cnt;
  logic signed [PW-1:0]      prod;
  logic signed [AW-1:0]      acc;
  logic signed [AW-1:0]      acc_nx;
  logic signed [AW-1:0]      shifted;
  logic signed [DATSIZE-1:0] res;
  logic signed [DATSIZE-1:0] res_fin;
  logic                      clip;
  logic signed [DATSIZE-1:0] out_data_q;
  logic                      out_ovf_q;

  assign beat      = bus.in_valid && in_ready_c;
  assign last_beat = beat && (cnt == LAST_CNT);

  assign prod    = PW'(bus.in_data) * PW'(bus.in_weight);
  assign acc_nx  = acc + AW'(prod);
  assign shifted = acc_nx >>> FPSHIFT;

  // Saturate the floored value into the signed output range.
  always_comb begin
    clip = 1'b0;
    res  = shifted[DATSIZE-1:0];
    if (shifted > SAT_MAX) begin
      clip = 1'b1;
      res  = RES_MAX;
    end else if (shifted < SAT_MIN) begin
      clip = 1'b1;
      res  = RES_MIN;
    end
  end

  always_comb begin
`ifdef MAC_SEQ_RELU_EN
    res_fin = res[DATSIZE-1] ? '0 : res;
`else
    res_fin = res;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACC: if (last_beat) state_nx = OUT;
      OUT: if (bus.out_ready) state_nx = ACC;
      default: state_nx = ACC;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state)
      ACC: in_ready_c  = 1'b1;
      OUT: out_valid_c = 1'b1;
      default: in_ready_c = 1'b0;
    endcase
  end

  // The result is latched on the last beat; accumulator clears on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      if (state == ACC && beat) begin
        acc <= acc_nx;
        if (last_beat) begin
          out_data_q <= res_fin;
          out_ovf_q  <= clip;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (state == OUT && bus.out_ready) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule
